// File: rtl/key_off_cfg_writer_if.sv
// Configuration-stream input and offset-table write port of one key_off_cfg_writer.
// master = upstream parser side, slave = the writer itself.
interface key_off_cfg_writer_if #(
  parameter int unsigned AXIL_WIDTH         = 32,
  parameter int unsigned KEY_OFF_ADDR_WIDTH = 4
);
  logic [AXIL_WIDTH-1:0]         cfg_data_in;
  logic                          cfg_valid_in;
  logic                          cfg_last_in;
  logic                          cfg_ready_out;
  logic [AXIL_WIDTH-1:0]         key_off_entry_out;
  logic                          key_off_entry_out_valid;
  logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_entry_addr;

  modport master (
    output cfg_data_in, cfg_valid_in, cfg_last_in,
    input  cfg_ready_out, key_off_entry_out, key_off_entry_out_valid, key_off_entry_addr
  );

  modport slave (
    input  cfg_data_in, cfg_valid_in, cfg_last_in,
    output cfg_ready_out, key_off_entry_out, key_off_entry_out_valid, key_off_entry_addr
  );
endinterface

// File: rtl/key_off_cfg_writer.sv
// Filters configuration packets by stage/resource type and writes each payload
// word into the key-extractor offset table at auto-incrementing, wrapping addresses.
module key_off_cfg_writer #(
  parameter int unsigned STAGE              = 0,
  parameter int unsigned AXIL_WIDTH         = 32,
  parameter int unsigned KEY_OFF_ADDR_WIDTH = 4,
  parameter logic [3:0]  RES_TYPE_KEY_OFF   = 4'h2,
  parameter int unsigned WR_GAP             = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  key_off_cfg_writer_if.slave      cfg,
  output logic                     busy_out,
  output logic [15:0]              wr_cnt_out,
  output logic [15:0]              err_cnt_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic                          rdy_en_q;
  logic [2:0]                    gap_q;
  logic [KEY_OFF_ADDR_WIDTH-1:0] addr_q;
  logic [4:0]                    remaining_q;

  logic                          beat;
  logic                          do_write;
  logic                          err_inc;
  logic                          load_hdr;

  logic [3:0] hdr_stage, hdr_type, hdr_addr, hdr_cnt;
  assign hdr_stage = cfg.cfg_data_in[31:28];
  assign hdr_type  = cfg.cfg_data_in[27:24];
  assign hdr_addr  = cfg.cfg_data_in[23:20];
  assign hdr_cnt   = cfg.cfg_data_in[19:16];

  // Ready is gated by a post-reset enable so it stays low while rst_n is asserted.
  assign cfg.cfg_ready_out = rdy_en_q & (gap_q == '0);
  assign beat              = cfg.cfg_valid_in & cfg.cfg_ready_out;
  assign busy_out          = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    err_inc  = 1'b0;
    load_hdr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          if (cfg.cfg_last_in) begin
            err_inc = 1'b1;
          end else if (hdr_stage != 4'(STAGE) || hdr_type != RES_TYPE_KEY_OFF) begin
            state_d = S_DROP;
          end else begin
            load_hdr = 1'b1;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (beat) begin
          do_write = 1'b1;
          if (remaining_q == 5'd1) begin
            if (cfg.cfg_last_in) begin
              state_d = S_IDLE;
            end else begin
              err_inc = 1'b1;
              state_d = S_DROP;
            end
          end else if (cfg.cfg_last_in) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (beat && cfg.cfg_last_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q                    <= 1'b0;
      gap_q                       <= '0;
      addr_q                      <= '0;
      remaining_q                 <= '0;
      wr_cnt_out                  <= '0;
      err_cnt_out                 <= '0;
      cfg.key_off_entry_out       <= '0;
      cfg.key_off_entry_addr      <= '0;
      cfg.key_off_entry_out_valid <= 1'b0;
    end else begin
      rdy_en_q                    <= 1'b1;
      cfg.key_off_entry_out_valid <= do_write;
      if (load_hdr) begin
        addr_q      <= KEY_OFF_ADDR_WIDTH'(hdr_addr);
        remaining_q <= {1'b0, hdr_cnt} + 5'd1;
      end
      if (do_write) begin
        cfg.key_off_entry_out  <= cfg.cfg_data_in;
        cfg.key_off_entry_addr <= addr_q;
        addr_q                 <= addr_q + 1'b1;
        remaining_q            <= remaining_q - 5'd1;
        wr_cnt_out             <= wr_cnt_out + 16'd1;
      end
      if (err_inc) err_cnt_out <= err_cnt_out + 16'd1;
      // Gap starts on the write beat, so ready drops in the same cycle as the strobe.
      if (do_write && WR_GAP != 0) gap_q <= 3'(WR_GAP);
      else if (gap_q != '0)        gap_q <= gap_q - 3'd1;
    end
  end

endmodule

// File: tb/tb_key_off_cfg_writer.sv
// Directed bench for key_off_cfg_writer: one instance with WR_GAP=0, one with WR_GAP=2.
module tb_key_off_cfg_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  key_off_cfg_writer_if #(.AXIL_WIDTH(32), .KEY_OFF_ADDR_WIDTH(4)) if0 ();
  key_off_cfg_writer_if #(.AXIL_WIDTH(32), .KEY_OFF_ADDR_WIDTH(4)) if1 ();
  logic        busy0, busy1;
  logic [15:0] wr0, wr1, err0, err1;

  key_off_cfg_writer #(.STAGE(0), .AXIL_WIDTH(32), .KEY_OFF_ADDR_WIDTH(4),
                       .RES_TYPE_KEY_OFF(4'h2), .WR_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg(if0.slave),
    .busy_out(busy0), .wr_cnt_out(wr0), .err_cnt_out(err0));

  key_off_cfg_writer #(.STAGE(0), .AXIL_WIDTH(32), .KEY_OFF_ADDR_WIDTH(4),
                       .RES_TYPE_KEY_OFF(4'h2), .WR_GAP(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg(if1.slave),
    .busy_out(busy1), .wr_cnt_out(wr1), .err_cnt_out(err1));

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    int unsigned c;
  } wr_t;
  wr_t  wq0[$];
  wr_t  wq1[$];
  logic rdy_log[$];

  always @(negedge clk) begin
    if (if0.key_off_entry_out_valid) wq0.push_back('{if0.key_off_entry_addr, if0.key_off_entry_out, cyc});
    if (if1.key_off_entry_out_valid) wq1.push_back('{if1.key_off_entry_addr, if1.key_off_entry_out, cyc});
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input int which, input logic [31:0] d, input logic l);
    int unsigned n;
    logic r;
    n = 0;
    if (which == 0) begin
      if0.cfg_valid_in = 1'b1; if0.cfg_data_in = d; if0.cfg_last_in = l;
      r = if0.cfg_ready_out;
    end else begin
      if1.cfg_valid_in = 1'b1; if1.cfg_data_in = d; if1.cfg_last_in = l;
      r = if1.cfg_ready_out;
    end
    while (!r && n < 50) begin
      if (which == 1) rdy_log.push_back(1'b0);
      @(negedge clk);
      n++;
      r = (which == 0) ? if0.cfg_ready_out : if1.cfg_ready_out;
    end
    total++;
    if (!r) begin
      bad++;
      $display("FAIL send_timeout dut%0d: ready=%b required=1", which, r);
    end else if (which == 1) rdy_log.push_back(1'b1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if0.cfg_valid_in = 1'b0; if0.cfg_last_in = 1'b0; if0.cfg_data_in = '0;
    if1.cfg_valid_in = 1'b0; if1.cfg_last_in = 1'b0; if1.cfg_data_in = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #3;
    total++;
    if ({if0.cfg_ready_out, if0.key_off_entry_out_valid, if0.key_off_entry_out, if0.key_off_entry_addr,
         busy0, wr0, err0} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b stb=%b entry=%h addr=%h busy=%b wr=%0d err=%0d required all 0",
               if0.cfg_ready_out, if0.key_off_entry_out_valid, if0.key_off_entry_out,
               if0.key_off_entry_addr, busy0, wr0, err0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (if0.cfg_ready_out !== 1'b0) begin bad++; $display("FAIL ready_at_release: got=%b required=0", if0.cfg_ready_out); end
    @(negedge clk);
    total++;
    if (if0.cfg_ready_out !== 1'b1) begin bad++; $display("FAIL ready_after_release: got=%b required=1", if0.cfg_ready_out); end
  endtask

  task automatic test_single_write();
    wq0.delete();
    send(0, 32'h0230_0000, 1'b0);
    total++;
    if (if0.key_off_entry_out_valid !== 1'b0) begin bad++; $display("FAIL hdr_no_strobe: got=%b required=0", if0.key_off_entry_out_valid); end
    send(0, 32'h0002_A6C5, 1'b1);
    idle_inputs();
    total++;
    if (if0.key_off_entry_out_valid !== 1'b1 || if0.key_off_entry_addr !== 4'd3 || if0.key_off_entry_out !== 32'h0002_A6C5) begin
      bad++;
      $display("FAIL single_write: stb=%b addr=%0d entry=%h required 1/3/0002a6c5",
               if0.key_off_entry_out_valid, if0.key_off_entry_addr, if0.key_off_entry_out);
    end
    @(negedge clk);
    total++;
    if (if0.key_off_entry_out_valid !== 1'b0 || if0.key_off_entry_out !== 32'h0002_A6C5 || if0.key_off_entry_addr !== 4'd3) begin
      bad++;
      $display("FAIL strobe_one_cycle_hold: stb=%b addr=%0d entry=%h required 0/3/0002a6c5",
               if0.key_off_entry_out_valid, if0.key_off_entry_addr, if0.key_off_entry_out);
    end
    total++;
    if (wr0 !== 16'd1 || err0 !== 16'd0 || busy0 !== 1'b0 || wq0.size() != 1) begin
      bad++;
      $display("FAIL single_counts: wr=%0d err=%0d busy=%b writes=%0d required 1/0/0/1", wr0, err0, busy0, wq0.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_a;
    wq0.delete();
    send(0, 32'h023E_0000, 1'b0);
    for (int unsigned i = 0; i < 15; i++) send(0, 32'h100 + i, i == 14);
    idle_inputs();
    @(negedge clk);
    total++;
    if (wq0.size() != 15) begin bad++; $display("FAIL b2b_count: got=%0d required=15", wq0.size()); end
    exp_a = 4'd3;
    for (int unsigned i = 0; i < wq0.size() && i < 15; i++) begin
      total++;
      if (wq0[i].a !== exp_a || wq0[i].d !== 32'h100 + i || (i > 0 && wq0[i].c != wq0[i-1].c + 1)) begin
        bad++;
        $display("FAIL b2b_write%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h consecutive",
                 i, wq0[i].a, wq0[i].d, wq0[i].c, exp_a, 32'h100 + i);
      end
      exp_a = exp_a + 4'd1;
    end
    total++;
    if (wr0 !== 16'd16 || err0 !== 16'd0 || busy0 !== 1'b0) begin
      bad++; $display("FAIL b2b_counts: wr=%0d err=%0d busy=%b required 16/0/0", wr0, err0, busy0);
    end
  endtask

  task automatic test_stage_filter();
    wq0.delete();
    send(0, 32'h1230_0000, 1'b0);
    for (int unsigned i = 0; i < 4; i++) send(0, 32'hDEAD_0000 + i, i == 3);
    idle_inputs();
    @(negedge clk);
    total++;
    if (wq0.size() != 0 || err0 !== 16'd0 || busy0 !== 1'b0) begin
      bad++; $display("FAIL drop_other_stage: writes=%0d err=%0d busy=%b required 0/0/0", wq0.size(), err0, busy0);
    end
    send(0, 32'h0250_0000, 1'b0);
    send(0, 32'h0000_0055, 1'b1);
    idle_inputs();
    @(negedge clk);
    total++;
    if (wq0.size() != 1 || wq0[0].a !== 4'd5 || wq0[0].d !== 32'h55 || wr0 !== 16'd17) begin
      bad++; $display("FAIL after_drop_write: writes=%0d wr=%0d required 1 write addr5 data 55, wr=17", wq0.size(), wr0);
    end
  endtask

  task automatic test_errors();
    wq0.delete();
    send(0, 32'h0202_0000, 1'b0);
    send(0, 32'h0000_0A00, 1'b0);
    send(0, 32'h0000_0A01, 1'b1);
    idle_inputs();
    @(negedge clk);
    total++;
    if (wq0.size() != 2 || err0 !== 16'd1 || busy0 !== 1'b0 || wr0 !== 16'd19) begin
      bad++; $display("FAIL early_last: writes=%0d err=%0d busy=%b wr=%0d required 2/1/0/19", wq0.size(), err0, busy0, wr0);
    end else begin
      total++;
      if (wq0[0].a !== 4'd0 || wq0[1].a !== 4'd1 || wq0[1].d !== 32'h0A01) begin
        bad++; $display("FAIL early_last_addr: a0=%0d a1=%0d d1=%h required 0/1/00000a01", wq0[0].a, wq0[1].a, wq0[1].d);
      end
    end
    wq0.delete();
    send(0, 32'h0202_0000, 1'b0);
    for (int unsigned i = 0; i < 5; i++) send(0, 32'h0B00 + i, i == 4);
    idle_inputs();
    @(negedge clk);
    total++;
    if (wq0.size() != 3 || err0 !== 16'd2 || busy0 !== 1'b0 || wr0 !== 16'd22) begin
      bad++; $display("FAIL missing_last: writes=%0d err=%0d busy=%b wr=%0d required 3/2/0/22", wq0.size(), err0, busy0, wr0);
    end else begin
      total++;
      if (wq0[2].a !== 4'd2 || wq0[2].d !== 32'h0B02) begin
        bad++; $display("FAIL missing_last_addr: a2=%0d d2=%h required 2/00000b02", wq0[2].a, wq0[2].d);
      end
    end
    send(0, 32'h0230_0000, 1'b1);
    idle_inputs();
    total++;
    if (err0 !== 16'd3 || busy0 !== 1'b0) begin
      bad++; $display("FAIL header_last: err=%0d busy=%b required 3/0", err0, busy0);
    end
  endtask

  task automatic test_wr_gap();
    logic exp_rdy [10];
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    wq1.delete();
    send(1, 32'h0243_0000, 1'b0);
    rdy_log.delete();
    for (int unsigned i = 0; i < 4; i++) send(1, 32'hA0 + i, i == 3);
    idle_inputs();
    @(negedge clk);
    total++;
    if (rdy_log.size() != 10) begin
      bad++; $display("FAIL gap_ready_len: got=%0d required=10", rdy_log.size());
    end else begin
      for (int unsigned i = 0; i < 10; i++) begin
        total++;
        if (rdy_log[i] !== exp_rdy[i]) begin bad++; $display("FAIL gap_ready%0d: got=%b required=%b", i, rdy_log[i], exp_rdy[i]); end
      end
    end
    total++;
    if (wq1.size() != 4 || wr1 !== 16'd4) begin
      bad++; $display("FAIL gap_count: writes=%0d wr=%0d required 4/4", wq1.size(), wr1);
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        total++;
        if (wq1[i].a !== 4'd4 + 4'(i) || wq1[i].d !== 32'hA0 + i || (i > 0 && wq1[i].c != wq1[i-1].c + 3)) begin
          bad++; $display("FAIL gap_write%0d: addr=%0d data=%h cyc=%0d required addr=%0d data=%h spacing 3",
                          i, wq1[i].a, wq1[i].d, wq1[i].c, 4 + i, 32'hA0 + i);
        end
      end
    end
    @(negedge clk);
    total++;
    if (if1.cfg_ready_out !== 1'b1) begin bad++; $display("FAIL gap_ready_return: got=%b required=1", if1.cfg_ready_out); end
  endtask

  task automatic test_reset_mid_packet();
    int unsigned n_before;
    send(0, 32'h023E_0000, 1'b0);
    for (int unsigned i = 0; i < 5; i++) send(0, 32'h200 + i, 1'b0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({if0.cfg_ready_out, if0.key_off_entry_out_valid, if0.key_off_entry_out, if0.key_off_entry_addr,
         busy0, wr0, err0} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: ready=%b stb=%b entry=%h addr=%h busy=%b wr=%0d err=%0d required all 0",
               if0.cfg_ready_out, if0.key_off_entry_out_valid, if0.key_off_entry_out,
               if0.key_off_entry_addr, busy0, wr0, err0);
    end
    n_before = wq0.size();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (wq0.size() != n_before || busy0 !== 1'b0) begin
      bad++; $display("FAIL mid_reset_no_strobe: writes=%0d busy=%b required %0d/0", wq0.size(), busy0, n_before);
    end
    wq0.delete();
    send(0, 32'h0200_0000, 1'b0);
    send(0, 32'h0000_ABCD, 1'b1);
    idle_inputs();
    total++;
    if (if0.key_off_entry_out_valid !== 1'b1 || if0.key_off_entry_addr !== 4'd0 || if0.key_off_entry_out !== 32'h0000_ABCD) begin
      bad++; $display("FAIL post_reset_write: stb=%b addr=%0d entry=%h required 1/0/0000abcd",
                      if0.key_off_entry_out_valid, if0.key_off_entry_addr, if0.key_off_entry_out);
    end
    @(negedge clk);
    total++;
    if (wr0 !== 16'd1 || err0 !== 16'd0) begin
      bad++; $display("FAIL post_reset_counts: wr=%0d err=%0d required 1/0", wr0, err0);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stage_filter();
    test_errors();
    test_wr_gap();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
